// File: rtl/noc_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module   : noc_cmd_initiator
// Purpose  : Bus-master end of the 8-bit NoC command protocol. Accepts one
//            parallel command and serialises it as header + 3 address beats
//            (+ WR_RES payload, MSB byte first). For RD_KEY / RD_TEXT it
//            collects the returned payload, then waits for the matching
//            ack-bus acknowledge before pulsing done.
// Options  : `define ACK_TIMEOUT_EN -> WAIT_ACK gives up after TIMEOUT_CYCLES
//            cycles with an err pulse. Without it WAIT_ACK waits forever.
// Ports    : clk, rst_n (async, active-low)
//            cmd_*        : command request / handshake / fields
//            bus_*        : outgoing beat stream (drive, valid, data, ready)
//            in_bus_*     : returning read beats (valid, data, ready)
//            ack_valid/id : ack bus
//            rd_data/rd_valid, done, err : results (1-cycle pulses)
// Revision : 1.0 - initial release
// ============================================================================
module noc_cmd_initiator #(
  parameter logic [1:0] MY_ID          = 2'b11,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_enc_dec,
  input  logic [1:0]   cmd_dest,
  input  logic [1:0]   cmd_source,
  input  logic [1:0]   cmd_opcode,
  input  logic [23:0]  cmd_addr,
  input  logic [255:0] cmd_wdata,
  output logic         bus_drive,
  output logic         bus_valid,
  output logic [7:0]   bus_data,
  input  logic         bus_ready,
  input  logic         in_bus_valid,
  input  logic [7:0]   in_bus_data,
  output logic         in_bus_ready,
  input  logic         ack_valid,
  input  logic [1:0]   ack_id,
  output logic [255:0] rd_data,
  output logic         rd_valid,
  output logic         done,
  output logic         err
);

  localparam logic [1:0] OP_RD_KEY  = 2'd0;
  localparam logic [1:0] OP_RD_TEXT = 2'd1;
  localparam logic [1:0] OP_WR_RES  = 2'd2;
  localparam logic [1:0] OP_HASH    = 2'd3;
  localparam logic [1:0] SRC_SHA    = 2'b01;
  localparam logic [1:0] SRC_AES    = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_HDR  = 3'd1,
    ST_SEND_DATA = 3'd2,
    ST_RECV_DATA = 3'd3,
    ST_WAIT_ACK  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;      // beat index within the current phase
  logic [4:0]     last_q, last_d;    // payload length minus one (15 or 31)
  logic [7:0]     hdr_q, hdr_d;
  logic [23:0]    addr_q, addr_d;
  logic [255:0]   wdata_q, wdata_d;
  logic [255:0]   rd_q, rd_d;
  logic           rd_valid_q, rd_valid_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           w_reject;
  logic [4:0]     w_byte_idx;

`ifdef ACK_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]    tmo_q, tmo_d;
`else
  // TIMEOUT_CYCLES has no effect in this build; the empty block only keeps
  // the parameter elaborated so both builds share one interface.
  if (TIMEOUT_CYCLES < 0) begin : g_no_timeout
  end
`endif

  // Writes may only originate from the hash or cipher engines.
  assign w_reject = (cmd_opcode == OP_WR_RES) &&
                    (cmd_source != SRC_SHA) && (cmd_source != SRC_AES);

  // Payload goes out MSB byte first: beat k carries byte (N-1-k).
  assign w_byte_idx = last_q - cnt_q[4:0];

  always_comb begin
    bus_data = 8'h00;
    case (state_q)
      ST_SEND_HDR: begin
        case (cnt_q[1:0])
          2'd0:    bus_data = hdr_q;
          2'd1:    bus_data = addr_q[7:0];
          2'd2:    bus_data = addr_q[15:8];
          default: bus_data = addr_q[23:16];
        endcase
      end
      ST_SEND_DATA: bus_data = wdata_q[{w_byte_idx, 3'b000} +: 8];
      default:      bus_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    hdr_d        = hdr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    rd_valid_d   = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
`ifdef ACK_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    cmd_ready    = 1'b0;
    bus_drive    = 1'b0;
    bus_valid    = 1'b0;
    in_bus_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (w_reject) begin
            err_d = 1'b1;
          end else begin
            hdr_d   = {cmd_enc_dec, 1'b0, cmd_dest, cmd_source, cmd_opcode};
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
            rd_d    = '0;
            cnt_d   = 6'd0;
            state_d = ST_SEND_HDR;
          end
        end
      end

      ST_SEND_HDR: begin
        bus_drive = 1'b1;
        bus_valid = 1'b1;
        if (bus_ready) begin
          if (cnt_q == 6'd3) begin
            cnt_d = 6'd0;
            case (hdr_q[1:0])
              OP_WR_RES: begin
                last_d  = (hdr_q[3:2] == SRC_SHA) ? 5'd31 : 5'd15;
                state_d = ST_SEND_DATA;
              end
              OP_RD_KEY: begin
                last_d  = 5'd31;
                state_d = ST_RECV_DATA;
              end
              OP_RD_TEXT: begin
                last_d  = 5'd15;
                state_d = ST_RECV_DATA;
              end
              OP_HASH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            endcase
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      ST_SEND_DATA: begin
        bus_drive = 1'b1;
        bus_valid = 1'b1;
        if (bus_ready) begin
          if (cnt_q == {1'b0, last_q}) begin
            cnt_d   = 6'd0;
            state_d = ST_WAIT_ACK;
`ifdef ACK_TIMEOUT_EN
            tmo_d   = 16'd0;
`endif
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      ST_RECV_DATA: begin
        in_bus_ready = 1'b1;
        if (in_bus_valid) begin
          rd_d = {rd_q[247:0], in_bus_data};
          if (cnt_q == {1'b0, last_q}) begin
            cnt_d      = 6'd0;
            rd_valid_d = 1'b1;
            state_d    = ST_WAIT_ACK;
`ifdef ACK_TIMEOUT_EN
            tmo_d      = 16'd0;
`endif
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      ST_WAIT_ACK: begin
        if (ack_valid && (ack_id == MY_ID)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
`ifdef ACK_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 6'd0;
      last_q     <= 5'd0;
      hdr_q      <= 8'h00;
      addr_q     <= 24'h0;
      wdata_q    <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef ACK_TIMEOUT_EN
      tmo_q      <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      hdr_q      <= hdr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef ACK_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign rd_data  = rd_q;
  assign rd_valid = rd_valid_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
`default_nettype wire
